// File: rtl/redirect_ctrl.sv
// redirect_ctrl: front-end redirect sequencer. It stalls fetch while a
// pre-decoded branch is outstanding, then hands one registered redirect PC
// to fetch over a valid/ready handshake. Exceptions and ertn override
// branch redirects and pulse a one-cycle pipeline flush.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   predecode_branch     fetched instruction is a branch
//   bru_valid/_taken     branch resolution strobe and direction
//   bru_target/bru_pc    taken target and PC of the resolved branch
//   exc_valid/exc_target exception or ertn commit and its target PC
//   fetch_ready          fetch accepts redirect_pc
//   redirect_valid/_pc   registered redirect request to fetch
//   fetch_stall          fetch holds its current PC
//   pipe_flush           kill everything younger than writeback
//   perf_*               event counters (only with REDIRECT_PERF_EN)
//
// Build option: define REDIRECT_PERF_EN to add the perf_* counters.

module redirect_ctrl #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h1c00_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            predecode_branch,
    input  logic            bru_valid,
    input  logic            bru_taken,
    input  logic [PC_W-1:0] bru_target,
    input  logic [PC_W-1:0] bru_pc,
    input  logic            exc_valid,
    input  logic [PC_W-1:0] exc_target,
    input  logic            fetch_ready,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            fetch_stall,
`ifdef REDIRECT_PERF_EN
    output logic [PC_W-1:0] perf_branch,
    output logic [PC_W-1:0] perf_taken,
    output logic [PC_W-1:0] perf_exc,
    output logic [PC_W-1:0] perf_stall,
`endif
    output logic            pipe_flush
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_BR = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    state_t          state_q;
    state_t          state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            flush_q;
    logic            flush_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    // An exception overrides whatever the state would otherwise do. In HOLD
    // with fetch_ready the old PC still transfers this cycle, because fetch
    // samples pc_q before the edge that loads exc_target.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = exc_valid;
        if (exc_valid) begin
            state_d = HOLD;
            pc_d    = exc_target;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (predecode_branch)
                        state_d = WAIT_BR;
                end
                WAIT_BR: begin
                    if (bru_valid) begin
                        state_d = HOLD;
                        pc_d    = bru_taken ? bru_target
                                            : bru_pc + PC_STEP;
                    end
                end
                HOLD: begin
                    if (fetch_ready)
                        state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign redirect_valid = (state_q == HOLD);
    assign fetch_stall    = (state_q != RUN);
    assign redirect_pc    = pc_q;
    assign pipe_flush     = flush_q;

`ifdef REDIRECT_PERF_EN
    logic            br_hit;
    logic [PC_W-1:0] cnt_branch;
    logic [PC_W-1:0] cnt_taken;
    logic [PC_W-1:0] cnt_exc;
    logic [PC_W-1:0] cnt_stall;

    // A resolution that loses to a same-cycle exception is not counted.
    assign br_hit = (state_q == WAIT_BR) && bru_valid && !exc_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_branch <= '0;
            cnt_taken  <= '0;
            cnt_exc    <= '0;
            cnt_stall  <= '0;
        end else begin
            if (br_hit)
                cnt_branch <= cnt_branch + 1'b1;
            if (br_hit && bru_taken)
                cnt_taken <= cnt_taken + 1'b1;
            if (exc_valid)
                cnt_exc <= cnt_exc + 1'b1;
            if (fetch_stall)
                cnt_stall <= cnt_stall + 1'b1;
        end
    end

    assign perf_branch = cnt_branch;
    assign perf_taken  = cnt_taken;
    assign perf_exc    = cnt_exc;
    assign perf_stall  = cnt_stall;
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// tb_redirect_ctrl: directed scenarios plus randomized traffic checked
// against a flag-based behavioural model of the redirect sequencer.

module tb_redirect_ctrl;

    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        predecode_branch;
    logic        bru_valid;
    logic        bru_taken;
    logic [31:0] bru_target;
    logic [31:0] bru_pc;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_stall;
    logic        pipe_flush;
`ifdef REDIRECT_PERF_EN
    logic [31:0] perf_branch;
    logic [31:0] perf_taken;
    logic [31:0] perf_exc;
    logic [31:0] perf_stall;
`endif

    redirect_ctrl #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .predecode_branch (predecode_branch),
        .bru_valid        (bru_valid),
        .bru_taken        (bru_taken),
        .bru_target       (bru_target),
        .bru_pc           (bru_pc),
        .exc_valid        (exc_valid),
        .exc_target       (exc_target),
        .fetch_ready      (fetch_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fetch_stall      (fetch_stall),
`ifdef REDIRECT_PERF_EN
        .perf_branch      (perf_branch),
        .perf_taken       (perf_taken),
        .perf_exc         (perf_exc),
        .perf_stall       (perf_stall),
`endif
        .pipe_flush       (pipe_flush)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int xfers = 0;

    // Reference model: "a branch is outstanding", "a redirect is pending".
    bit          m_wait;
    bit          m_pend;
    bit          m_flush;
    logic [31:0] m_pc;

    always @(posedge clk)
        if (!rst && redirect_valid && fetch_ready)
            xfers <= xfers + 1;

    task automatic idle();
        predecode_branch = 1'b0;
        bru_valid        = 1'b0;
        bru_taken        = 1'b0;
        bru_target       = 32'h0;
        bru_pc           = 32'h0;
        exc_valid        = 1'b0;
        exc_target       = 32'h0;
        fetch_ready      = 1'b0;
    endtask

    task automatic model_reset();
        m_wait  = 1'b0;
        m_pend  = 1'b0;
        m_flush = 1'b0;
        m_pc    = RESET_PC;
    endtask

    // Advance one clock, update the model from the inputs seen at the edge,
    // and return 1 time unit later so outputs can be sampled.
    task automatic cyc();
        @(posedge clk);
        m_flush = exc_valid;
        if (exc_valid) begin
            m_wait = 1'b0;
            m_pend = 1'b1;
            m_pc   = exc_target;
        end else if (m_wait) begin
            if (bru_valid) begin
                m_wait = 1'b0;
                m_pend = 1'b1;
                m_pc   = bru_taken ? bru_target : bru_pc + 32'd4;
            end
        end else if (m_pend) begin
            if (fetch_ready) m_pend = 1'b0;
        end else if (predecode_branch) begin
            m_wait = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        total++;
        if (redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid got=%0b exp=0", redirect_valid);
        end
        total++;
        if (redirect_pc !== RESET_PC) begin
            bad++;
            $display("FAIL rst_pc got=%h exp=%h", redirect_pc, RESET_PC);
        end
        total++;
        if (fetch_stall !== 1'b0 || pipe_flush !== 1'b0) begin
            bad++;
            $display("FAIL rst_stall_flush got=%0b%0b exp=00",
                     fetch_stall, pipe_flush);
        end
    endtask

    task automatic test_not_taken();
        predecode_branch = 1'b1;
        cyc();
        predecode_branch = 1'b0;
        total++;
        if (fetch_stall !== 1'b1 || redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL nt_stall got=%0b/%0b exp=1/0",
                     fetch_stall, redirect_valid);
        end
        cyc();
        cyc();
        bru_valid  = 1'b1;
        bru_taken  = 1'b0;
        bru_pc     = 32'h1c00_0010;
        bru_target = 32'hdead_beec;
        cyc();
        idle();
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00_0014) begin
            bad++;
            $display("FAIL nt_redirect got=%0b/%h exp=1/1c000014",
                     redirect_valid, redirect_pc);
        end
        fetch_ready = 1'b1;
        cyc();
        fetch_ready = 1'b0;
        total++;
        if (redirect_valid !== 1'b0 || fetch_stall !== 1'b0) begin
            bad++;
            $display("FAIL nt_run got=%0b/%0b exp=0/0",
                     redirect_valid, fetch_stall);
        end
    endtask

    task automatic test_backpressure();
        int x0;
        predecode_branch = 1'b1;
        cyc();
        idle();
        bru_valid  = 1'b1;
        bru_taken  = 1'b1;
        bru_target = 32'h1c00_0100;
        bru_pc     = 32'h1c00_0040;
        cyc();
        idle();
        x0 = xfers;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00_0100) begin
                bad++;
                $display("FAIL bp_hold%0d got=%0b/%h exp=1/1c000100",
                         i, redirect_valid, redirect_pc);
            end
            fetch_ready = (i == 3);
            cyc();
        end
        fetch_ready = 1'b0;
        cyc();
        cyc();
        total++;
        if (xfers - x0 != 1 || redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_xfer got=%0d/%0b exp=1/0",
                     xfers - x0, redirect_valid);
        end
    endtask

    task automatic test_exc_wait();
        predecode_branch = 1'b1;
        cyc();
        idle();
        exc_valid  = 1'b1;
        exc_target = 32'h1c00_8000;
        cyc();
        idle();
        total++;
        if (pipe_flush !== 1'b1 || redirect_valid !== 1'b1 ||
            redirect_pc !== 32'h1c00_8000) begin
            bad++;
            $display("FAIL exc_take got=%0b/%0b/%h exp=1/1/1c008000",
                     pipe_flush, redirect_valid, redirect_pc);
        end
        bru_valid  = 1'b1;
        bru_taken  = 1'b1;
        bru_target = 32'h1234_5678;
        cyc();
        idle();
        total++;
        if (pipe_flush !== 1'b0 || redirect_pc !== 32'h1c00_8000) begin
            bad++;
            $display("FAIL exc_pulse got=%0b/%h exp=0/1c008000",
                     pipe_flush, redirect_pc);
        end
        fetch_ready = 1'b1;
        cyc();
        idle();
        bru_valid  = 1'b1;
        bru_target = 32'h1234_5678;
        cyc();
        idle();
        total++;
        if (redirect_valid !== 1'b0 || fetch_stall !== 1'b0) begin
            bad++;
            $display("FAIL exc_stray_bru got=%0b/%0b exp=0/0",
                     redirect_valid, fetch_stall);
        end
    endtask

    task automatic test_exc_bru_same();
`ifdef REDIRECT_PERF_EN
        logic [31:0] pb0 = perf_branch;
`endif
        predecode_branch = 1'b1;
        cyc();
        idle();
        exc_valid  = 1'b1;
        exc_target = 32'h1c00_8040;
        bru_valid  = 1'b1;
        bru_taken  = 1'b1;
        bru_target = 32'h1c00_0200;
        cyc();
        idle();
        total++;
        if (redirect_pc !== 32'h1c00_8040 || pipe_flush !== 1'b1) begin
            bad++;
            $display("FAIL same_exc_bru got=%h/%0b exp=1c008040/1",
                     redirect_pc, pipe_flush);
        end
`ifdef REDIRECT_PERF_EN
        total++;
        if (perf_branch !== pb0) begin
            bad++;
            $display("FAIL same_perf got=%0d exp=%0d", perf_branch, pb0);
        end
`endif
        fetch_ready = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_hold_exc_ready();
        int x0;
        predecode_branch = 1'b1;
        cyc();
        idle();
        bru_valid  = 1'b1;
        bru_taken  = 1'b1;
        bru_target = 32'h1c00_0300;
        cyc();
        idle();
        x0          = xfers;
        fetch_ready = 1'b1;
        exc_valid   = 1'b1;
        exc_target  = 32'h1c00_9000;
        cyc();
        idle();
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00_9000 ||
            xfers - x0 != 1) begin
            bad++;
            $display("FAIL hold_exc_rdy got=%0b/%h/%0d exp=1/1c009000/1",
                     redirect_valid, redirect_pc, xfers - x0);
        end
        fetch_ready = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_wrap();
        predecode_branch = 1'b1;
        cyc();
        idle();
        bru_valid  = 1'b1;
        bru_taken  = 1'b0;
        bru_pc     = 32'hffff_fffc;
        bru_target = 32'h1c00_0500;
        cyc();
        idle();
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin
            bad++;
            $display("FAIL wrap got=%0b/%h exp=1/00000000",
                     redirect_valid, redirect_pc);
        end
        fetch_ready = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_async_rst();
        predecode_branch = 1'b1;
        cyc();
        idle();
        bru_valid  = 1'b1;
        bru_taken  = 1'b1;
        bru_target = 32'h1c00_0600;
        cyc();
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (redirect_valid !== 1'b0 || redirect_pc !== RESET_PC ||
            fetch_stall !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got=%0b/%h/%0b exp=0/%h/0",
                     redirect_valid, redirect_pc, fetch_stall, RESET_PC);
        end
        #1;
        rst = 1'b0;
        model_reset();
        predecode_branch = 1'b1;
        cyc();
        idle();
        total++;
        if (fetch_stall !== 1'b1 || redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_then_br got=%0b/%0b exp=1/0",
                     fetch_stall, redirect_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            predecode_branch = ($urandom_range(0, 9) < 3);
            bru_valid        = ($urandom_range(0, 9) < 3);
            bru_taken        = $urandom_range(0, 1) == 1;
            bru_target       = $urandom;
            bru_pc           = (i % 50 == 7) ? 32'hffff_fffc : $urandom;
            exc_valid        = ($urandom_range(0, 19) == 0);
            exc_target       = $urandom;
            fetch_ready      = $urandom_range(0, 1) == 1;
            cyc();
            total++;
            if (redirect_valid !== m_pend || fetch_stall !== (m_wait | m_pend)) begin
                bad++;
                $display("FAIL rnd_ctl%0d got=%0b/%0b exp=%0b/%0b", i,
                         redirect_valid, fetch_stall, m_pend, m_wait | m_pend);
            end
            total++;
            if (redirect_pc !== m_pc || pipe_flush !== m_flush) begin
                bad++;
                $display("FAIL rnd_pc%0d got=%h/%0b exp=%h/%0b", i,
                         redirect_pc, pipe_flush, m_pc, m_flush);
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_not_taken();
        test_backpressure();
        test_exc_wait();
        test_exc_bru_same();
        test_hold_exc_ready();
        test_wrap();
        test_async_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Front-end redirect sequencer between the branch pre-decoder, the branch resolution unit (BRU), the writeback exception/ertn path and the fetch stage. When pre-decode flags a branch, it stalls fetch until the BRU resolves that branch. It then presents a single registered redirect PC to fetch over a valid/ready handshake. Exceptions always take priority over branch redirects and also pulse a pipeline flush.

## Interface
- `PC_W`, 32, PC width in bits.
- `RESET_PC`, 32'h1c00_0000, value of `redirect_pc` out of reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `predecode_branch` in 1: the fetched instruction decodes as a branch.
- `bru_valid` in 1: BRU resolves the outstanding branch this cycle.
- `bru_taken` in 1: the resolved branch is taken.
- `bru_target` in PC_W: target PC of the taken branch.
- `bru_pc` in PC_W: PC of the resolved branch.
- `exc_valid` in 1: exception or ertn committed in writeback.
- `exc_target` in PC_W: exception entry PC or ertn return PC.
- `fetch_ready` in 1: fetch accepts `redirect_pc` this cycle.
- `redirect_valid` out 1: `redirect_pc` is valid and must be taken.
- `redirect_pc` out PC_W: the new fetch PC.
- `fetch_stall` out 1: fetch holds its current PC.
- `pipe_flush` out 1: one-cycle pulse that kills all stages younger than writeback.

## Operation
- State machine with three states: RUN, WAIT_BR, HOLD. Reset puts the block in RUN.
- RUN:
  - `predecode_branch`=1 -> go to WAIT_BR.
  - `bru_valid` with no outstanding branch is a protocol violation and is ignored; no redirect is issued.
- WAIT_BR:
  - `bru_valid`=1 -> latch the redirect PC and go to HOLD.
  - The redirect PC is `bru_taken ? bru_target : bru_pc+4`. `bru_pc+4` is computed modulo 2^PC_W, so it wraps silently.
  - `predecode_branch` is ignored in this state, because fetch is stalled and re-presents the same instruction.
- HOLD:
  - `redirect_valid`=1 and `redirect_pc` stays stable until `fetch_ready`=1.
  - On `fetch_ready` the block returns to RUN.
  - `predecode_branch` is ignored.
- Exceptions, in any state:
  - `exc_valid`=1 latches `exc_target` into `redirect_pc`, registers `pipe_flush`=1 for exactly one cycle, and forces HOLD.
  - Any outstanding WAIT_BR, or any pending branch redirect in HOLD, is discarded.
- Priority: `exc_valid` beats `bru_valid`, which beats `predecode_branch`.
- Simultaneous events:
  - HOLD, `fetch_ready`=1 and `exc_valid`=1 together: the current handshake completes with the old PC. The block stays in HOLD with `exc_target`.
  - RUN, `predecode_branch`=1 and `exc_valid`=1 together: the block goes to HOLD with `exc_target`, and the branch is dropped.
- `fetch_stall` is a decode of the state: 1 in WAIT_BR and in HOLD.
- `redirect_valid` is a decode of the state: 1 only in HOLD.

## Timing
- Reset values, asynchronous: state RUN, `redirect_valid`=0, `redirect_pc`=RESET_PC, `fetch_stall`=0, `pipe_flush`=0.
- Reset asserted mid-operation clears all state immediately and drops any pending redirect.
- Latencies:
  - `predecode_branch` in cycle N -> `fetch_stall`=1 from cycle N+1.
  - `bru_valid` in cycle N -> `redirect_valid`=1 with the new PC in cycle N+1.
  - `exc_valid` in cycle N -> `pipe_flush` and `redirect_valid` in cycle N+1.
- Handshake: the redirect transfers in a cycle where `redirect_valid` && `fetch_ready`. In the next cycle `redirect_valid`=0, unless a new exception was latched in the same cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Configuration
- `REDIRECT_PERF_EN` defined: adds four PC_W-wide output counters.
  - `perf_branch`: branches resolved in WAIT_BR.
  - `perf_taken`: resolved branches that were taken.
  - `perf_exc`: exceptions accepted.
  - `perf_stall`: cycles with `fetch_stall`=1.
  - All counters reset to 0 and wrap on overflow.
- `REDIRECT_PERF_EN` undefined: the counters and their ports are absent; behaviour is otherwise identical.

## Test plan
- Not-taken branch: `predecode_branch` at cycle 2, then `bru_valid`, taken=0, `bru_pc`=0x1c000010 at cycle 5 -> `fetch_stall` high cycles 3-6; `redirect_pc`=0x1c000014 valid at cycle 6; `fetch_ready`=1 at cycle 6 -> RUN at cycle 7.
- Taken branch with fetch back-pressure: target 0x1c000100 and `fetch_ready` held 0 for 3 cycles -> `redirect_valid` and PC stay stable for 4 cycles; exactly one transfer occurs.
- Exception during WAIT_BR: `exc_valid` with target 0x1c008000 -> `pipe_flush` pulses 1 cycle; `redirect_pc`=0x1c008000; a later `bru_valid` is ignored.
- Same-cycle `exc_valid` and `bru_valid` in WAIT_BR -> the exception target wins; `perf_branch` is unchanged when `REDIRECT_PERF_EN` is defined.
- Wrap: `bru_pc`=0xfffffffc, not taken -> `redirect_pc`=0x00000000.
- Async `rst` pulsed mid-HOLD, between clock edges -> `redirect_valid`=0 and `redirect_pc`=RESET_PC immediately; the next `predecode_branch` behaves normally.
